// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory with dump sequencer.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

  localparam int WORD_BYTES  = 8;
  localparam int BYTE_OFFSET = 3;

endpackage

// File: rtl/dmem_dump_fsm.sv
// Dump sequencer: detects the dump request edge and walks every word index
// over a valid/ready channel, finishing with a one-cycle done pulse.
module dmem_dump_fsm
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_i,
  input  logic          dump_ready_i,
  output logic [AW-1:0] ptr_o,
  output logic          dump_valid_o,
  output logic          dump_busy_o,
  output logic          dump_done_o
);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          dump_q;
  logic          dump_rise;

  assign dump_rise = dump_i && !dump_q;
  assign ptr_o     = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dump_q  <= dump_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    dump_valid_o = 1'b0;
    dump_busy_o  = 1'b0;
    dump_done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_rise) begin
          ptr_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        dump_valid_o = 1'b1;
        dump_busy_o  = 1'b1;
        // Pointer only moves on an accepted beat, so addr/data hold under backpressure.
        if (dump_ready_i) begin
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      DONE: begin
        dump_done_o = 1'b1;
        dump_busy_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/data_memory_dump.sv
// Data memory slave: synchronous-write, combinational-read word store with a
// dump sequencer that streams the whole array out on request.
module data_memory_dump
  import dmem_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 64
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         memWrite,
  input  logic         memRead,
  input  logic [N-1:0] address,
  input  logic [N-1:0] writeData,
  output logic [N-1:0] readData,
  input  logic         dump,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_busy,
  output logic         dump_done,
  output logic         dropped_write
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [AW-1:0] ptr;
  logic          dropped_q;
  logic          write_en;
  logic          unused_addr_bits;

  // Byte offset and bits above the word index are ignored: misaligned
  // addresses truncate, out-of-range addresses wrap.
  assign idx              = address[AW+BYTE_OFFSET-1:BYTE_OFFSET];
  assign unused_addr_bits = ^{address[N-1:AW+BYTE_OFFSET], address[BYTE_OFFSET-1:0]};
  assign write_en         = memWrite && !dump_busy;

  dmem_dump_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dump_fsm (
    .clk          (CLOCK_50),
    .rst_n        (reset),
    .dump_i       (dump),
    .dump_ready_i (dump_ready),
    .ptr_o        (ptr),
    .dump_valid_o (dump_valid),
    .dump_busy_o  (dump_busy),
    .dump_done_o  (dump_done)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_en) begin
      mem_q[idx] <= writeData;
    end
  end

  // Stores are refused while the array is being streamed; remember that one was lost.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      dropped_q <= 1'b0;
    end else if (memWrite && dump_busy) begin
      dropped_q <= 1'b1;
    end
  end

  assign dropped_write = dropped_q;
  assign readData      = memRead ? mem_q[idx] : '0;
  assign dump_addr     = dump_valid ? {{(N-AW-BYTE_OFFSET){1'b0}}, ptr, {BYTE_OFFSET{1'b0}}} : '0;
  assign dump_data     = dump_valid ? mem_q[ptr] : '0;

endmodule
